// File: rtl/measure_display.sv
// Sequential binary-to-BCD converter driving four active-low seven-segment digits.
// A new value is sampled on update; digits and overflow change together once conversion ends.
module measure_display #(
    parameter int IN_WIDTH      = 14,
    parameter bit BLANK_LEADING = 1'b1,
    parameter int MAX_DISPLAY   = 9999
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                update,
    input  logic [IN_WIDTH-1:0] num,
    input  logic [2:0]          measurement,
    output logic [6:0]          hex0,
    output logic [6:0]          hex1,
    output logic [6:0]          hex2,
    output logic [6:0]          hex3,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [1:0]          dbg_state
);

    // Handshake: update is a level sampled on a rising edge; while busy, requests merge into pending.
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    localparam logic [IN_WIDTH-1:0] MAX_VAL    = IN_WIDTH'(MAX_DISPLAY);
    localparam logic [3:0]          LAST_SHIFT = 4'(IN_WIDTH - 1);
    localparam logic [6:0]          SEG_BLANK  = 7'h7F;

    state_t              r_state;
    state_t              w_next;
    logic [IN_WIDTH-1:0] r_val;
    logic [15:0]         r_bcd;
    logic [3:0]          r_cnt;
    logic                r_ovf;
    logic [2:0]          r_mode;
    logic                r_pending;
    logic [6:0]          r_hex0, r_hex1, r_hex2, r_hex3;
    logic                r_done;
    logic                r_overflow;

    logic                w_load;
    logic [15:0]         w_adj;
    logic [3:0]          w_d0, w_d1, w_d2, w_d3;
    logic                w_blank0, w_blank1, w_blank2, w_blank3;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (update) w_next = S_SHIFT;
            S_LOAD:  w_next = S_SHIFT;
            S_SHIFT: if (r_cnt == LAST_SHIFT) w_next = S_DONE;
            S_DONE:  w_next = (r_pending || update) ? S_LOAD : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_load = ((r_state == S_IDLE) && update) || (r_state == S_LOAD);

    // Add-3 correction on every BCD nibble before the shift.
    always_comb begin
        w_adj = r_bcd;
        for (int k = 0; k < 4; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
        end
    end

    assign w_d0 = r_bcd[3:0];
    assign w_d1 = r_bcd[7:4];
    assign w_d2 = r_bcd[11:8];
    assign w_d3 = r_bcd[15:12];

    assign w_blank3 = (r_mode == 3'd0) || (BLANK_LEADING && (w_d3 == 4'd0));
    assign w_blank2 = (r_mode == 3'd0) || (BLANK_LEADING && (w_d3 == 4'd0) && (w_d2 == 4'd0));
    assign w_blank1 = (r_mode == 3'd0) ||
                      (BLANK_LEADING && (w_d3 == 4'd0) && (w_d2 == 4'd0) && (w_d1 == 4'd0));
    assign w_blank0 = (r_mode == 3'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_val      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_mode     <= '0;
            r_pending  <= 1'b0;
            r_hex0     <= SEG_BLANK;
            r_hex1     <= SEG_BLANK;
            r_hex2     <= SEG_BLANK;
            r_hex3     <= SEG_BLANK;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_val  <= (num > MAX_VAL) ? MAX_VAL : num;
                r_ovf  <= (num > MAX_VAL);
                r_mode <= measurement;
                r_bcd  <= '0;
                r_cnt  <= '0;
            end
            if (r_state == S_SHIFT) begin
                r_bcd <= {w_adj[14:0], r_val[IN_WIDTH-1]};
                r_val <= {r_val[IN_WIDTH-2:0], 1'b0};
                r_cnt <= r_cnt + 4'd1;
                if (update) r_pending <= 1'b1;
            end
            if (r_state == S_DONE) begin
                r_hex0     <= w_blank0 ? SEG_BLANK : seg7(w_d0);
                r_hex1     <= w_blank1 ? SEG_BLANK : seg7(w_d1);
                r_hex2     <= w_blank2 ? SEG_BLANK : seg7(w_d2);
                r_hex3     <= w_blank3 ? SEG_BLANK : seg7(w_d3);
                r_overflow <= (r_mode != 3'd0) && r_ovf;
                r_done     <= 1'b1;
                r_pending  <= 1'b0;
            end
        end
    end

    assign hex0      = r_hex0;
    assign hex1      = r_hex1;
    assign hex2      = r_hex2;
    assign hex3      = r_hex3;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign overflow  = r_overflow;
    assign dbg_state = r_state;

endmodule
